// File: rtl/disassemble_msg.sv
// ============================================================================
// Module   : disassemble_msg
// Brief    : Serializes a MSG_SIZE-bit word into KEY_SIZE-bit chunks, MSB
//            chunk first, over a valid/ready handshake with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module disassemble_msg #(
    parameter int KEY_SIZE = 4,
    parameter int MSG_SIZE = 8,
    localparam int NCHUNK  = MSG_SIZE / KEY_SIZE,
    localparam int CW      = $clog2(NCHUNK + 1)
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iLoad,
    input  logic [MSG_SIZE-1:0] iData,
    input  logic                iReady,
    output logic [KEY_SIZE-1:0] oChunk,
    output logic                oValid,
    output logic                oBusy,
    output logic                oDone,
    output logic [CW-1:0]       oCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MSG_SIZE-1:0] shreg_q, shreg_d;
    logic [KEY_SIZE-1:0] chunk_q, chunk_d;
    logic                valid_q, valid_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic [CW-1:0]       count_q, count_d;

    logic [MSG_SIZE-1:0] w_shifted;
    logic                w_xfer;

    assign w_shifted = shreg_q << KEY_SIZE;
    assign w_xfer    = valid_q && iReady && iEn;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        chunk_d = chunk_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        count_d = count_q;
        // With iEn low every register simply holds its value.
        if (iEn) begin
            case (state_q)
                ST_IDLE: begin
                    if (iLoad) begin
                        state_d = ST_SEND;
                        shreg_d = iData;
                        chunk_d = iData[MSG_SIZE-1 -: KEY_SIZE];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        count_d = CW'(NCHUNK);
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        shreg_d = w_shifted;
                        if (count_q == CW'(1)) begin
                            state_d = ST_DONE;
                            chunk_d = '0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            count_d = '0;
                        end else begin
                            chunk_d = w_shifted[MSG_SIZE-1 -: KEY_SIZE];
                            count_d = count_q - CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    chunk_d = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            chunk_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            chunk_q <= chunk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign oChunk = chunk_q;
    assign oValid = valid_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_disassemble_msg.sv
// ============================================================================
// Module   : tb_disassemble_msg
// Brief    : Scoreboard bench for disassemble_msg (8-bit word) plus a 16-bit
//            loopback into a behavioural key assembler.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_disassemble_msg;

    localparam int KEY    = 4;
    localparam int MSG    = 8;
    localparam int NCHUNK = MSG / KEY;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic           iClk = 1'b0;
    logic           iRst = 1'b0;
    logic           iEn = 1'b1, iLoad = 1'b0, iReady = 1'b1;
    logic [MSG-1:0] iData = '0;
    logic [KEY-1:0] oChunk;
    logic           oValid, oBusy, oDone;
    logic [CW-1:0]  oCount;

    logic           l_load = 1'b0, l_en = 1'b1, l_ready = 1'b1;
    logic [15:0]    l_data = '0;
    logic [KEY-1:0] l_chunk;
    logic           l_valid, l_busy, l_done;
    logic [2:0]     l_count;
    logic [15:0]    asm16 = '0;

    int checks = 0;
    int failures = 0;

    always #5 iClk = ~iClk;

    disassemble_msg #(.KEY_SIZE(KEY), .MSG_SIZE(MSG)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iLoad(iLoad), .iData(iData),
        .iReady(iReady), .oChunk(oChunk), .oValid(oValid), .oBusy(oBusy),
        .oDone(oDone), .oCount(oCount)
    );

    disassemble_msg #(.KEY_SIZE(KEY), .MSG_SIZE(16)) dut16 (
        .iClk(iClk), .iRst(iRst), .iEn(l_en), .iLoad(l_load), .iData(l_data),
        .iReady(l_ready), .oChunk(l_chunk), .oValid(l_valid), .oBusy(l_busy),
        .oDone(l_done), .oCount(l_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is either absent, being sent (with a number of
    // chunks left), or just finished. Expected chunks are queued at load time.
    int             m_phase = 0;   // 0 idle, 1 sending, 2 finished
    int             m_left  = 0;
    logic [KEY-1:0] sb[$];

    always @(posedge iClk or negedge iRst) begin
        logic [MSG-1:0] part;
        if (!iRst) begin
            m_phase = 0;
            m_left  = 0;
            sb.delete();
        end else if (iEn) begin
            case (m_phase)
                0: if (iLoad) begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        part = iData >> (KEY * (NCHUNK - 1 - i));
                        sb.push_back(part[KEY-1:0]);
                    end
                    m_left  = NCHUNK;
                    m_phase = 1;
                end
                1: if (iReady) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Monitor: compares every cycle, pops a chunk on each observed handshake.
    always @(negedge iClk) begin
        logic [KEY-1:0] exp_chunk;
        exp_chunk = '0;
        chk("valid", 32'(oValid), 32'(m_phase == 1));
        chk("busy",  32'(oBusy),  32'(m_phase != 0));
        chk("done",  32'(oDone),  32'(m_phase == 2));
        chk("count", 32'(oCount), 32'(m_left));
        if (m_phase == 1) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(0), 32'(1));
            else exp_chunk = sb[0];
        end
        chk("chunk", 32'(oChunk), 32'(exp_chunk));
        if (m_phase == 2) chk("sb_leftover", 32'(sb.size()), 32'(0));
        if (oValid && iReady && iEn && sb.size() > 0) void'(sb.pop_front());
    end

    // Behavioural key assembler fed by the 16-bit serializer.
    always @(posedge iClk)
        if (iRst && l_valid && l_ready && l_en) asm16 <= {asm16[11:0], l_chunk};

    task automatic cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_phase == 0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    task automatic load(input logic [MSG-1:0] d);
        iLoad = 1'b1;
        iData = d;
        cycle();
        iLoad = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_chunk"}, 32'(oChunk), 32'(0));
        chk({tag, "_valid"}, 32'(oValid), 32'(0));
        chk({tag, "_busy"},  32'(oBusy),  32'(0));
        chk({tag, "_done"},  32'(oDone),  32'(0));
        chk({tag, "_count"}, 32'(oCount), 32'(0));
    endtask

    initial begin
        logic [15:0] words[3];
        bit          seen;

        #12;
        chk_zero("reset");
        iRst = 1'b1;
        cycle();

        wait_idle(); load(8'hA5); wait_idle();

        iReady = 1'b0; load(8'h3C);
        repeat (3) cycle();
        iReady = 1'b1; wait_idle();

        load(8'h5A);
        iEn = 1'b0; repeat (4) cycle();
        iEn = 1'b1; wait_idle();

        load(8'h12);
        iLoad = 1'b1; iData = 8'hFF; cycle(); iLoad = 1'b0;
        wait_idle(); load(8'hFF); wait_idle();

        load(8'h96);
        cycle();
        #2 iRst = 1'b0;
        #1 chk_zero("async_rst");
        cycle();
        iRst = 1'b1;
        repeat (2) cycle();
        wait_idle(); load(8'h47); wait_idle();

        for (int c = 0; c < 3000; c++) begin
            iLoad  = ($urandom_range(0, 9) < 3);
            iData  = MSG'($urandom);
            iReady = ($urandom_range(0, 9) < 6);
            iEn    = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 299) == 0) begin
                #2 iRst = 1'b0;
                #1 chk_zero("rand_rst");
                cycle();
                iRst = 1'b1;
            end
            cycle();
        end
        iLoad = 1'b0; iReady = 1'b1; iEn = 1'b1;
        wait_idle();

        words[0] = 16'hBEEF;
        words[1] = 16'($urandom);
        words[2] = 16'($urandom);
        foreach (words[k]) begin
            repeat (2) cycle();
            l_load = 1'b1; l_data = words[k]; cycle(); l_load = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (l_done) begin
                    seen = 1'b1;
                    break;
                end
                cycle();
            end
            chk("loop_done_seen", 32'(seen), 32'(1));
            chk("loopback_word", 32'(asm16), 32'(words[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
